// File: rtl/div_pkg.sv
// div_pkg: op/state encodings shared by the sequential divider
package div_pkg;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  typedef enum logic [1:0] {DIV = OP_DIV, DIVU = OP_DIVU, REM = OP_REM, REMU = OP_REMU} div_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-and-subtract step of the divider
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);
  logic [XLEN:0] trial;
  assign trial = {rem_i, bit_i} - {1'b0, divisor_i};
  assign q_o   = ~trial[XLEN];
  assign rem_o = q_o ? trial[XLEN-1:0] : {rem_i[XLEN-2:0], bit_i};
endmodule

// File: rtl/div_unit_seq.sv
// div_unit_seq: iterative RV32M/RV64M DIV/DIVU/REM/REMU, one quotient bit per clock.
// DIV_UNIT_EARLY_OUT_EN: divide-by-zero and signed overflow finish in one cycle.
module div_unit_seq
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);
  div_state_t      state_q, state_d;
  div_op_t         op_q;
  logic            neg_quot_q, neg_rem_q, done_q;
  logic [XLEN-1:0] rem_q, quot_q, dsr_q, result_q;
  logic [CW-1:0]   cnt_q;
  logic            sgn, a_neg, b_neg, early, step_q;
  logic [XLEN-1:0] a_abs, b_abs, step_rem, quot_fix, rem_fix, early_res;
  assign sgn   = ~op[0];
  assign a_neg = sgn & dividend[XLEN-1];
  assign b_neg = sgn & divisor[XLEN-1];
  assign a_abs = a_neg ? -dividend : dividend;
  assign b_abs = b_neg ? -divisor : divisor;
`ifdef DIV_UNIT_EARLY_OUT_EN
  logic dz_in, ovf_in;
  assign dz_in     = divisor == '0;
  assign ovf_in    = sgn && dividend == {1'b1, {(XLEN-1){1'b0}}} && &divisor;
  assign early     = start && (dz_in || ovf_in);
  assign early_res = op[1] ? (dz_in ? dividend : '0) : (dz_in ? '1 : dividend);
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif
  div_step #(.XLEN(XLEN)) u_step (
    .rem_i    (rem_q),
    .bit_i    (quot_q[XLEN-1]),
    .divisor_i(dsr_q),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );
  // quotient sign is cleared at latch time for a zero divisor so it stays all ones
  assign quot_fix = neg_quot_q ? -quot_q : quot_q;
  assign rem_fix  = neg_rem_q ? -rem_q : rem_q;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (start && !early) ? CALC : IDLE;
      CALC:    state_d = (cnt_q == CW'(1)) ? FIX : CALC;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy   = state_q != IDLE;
    done   = done_q;
    result = result_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= DIV;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      rem_q      <= '0;
      quot_q     <= '0;
      dsr_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE && start && early) begin
        result_q <= early_res;
        done_q   <= 1'b1;
      end else if (state_q == IDLE && start) begin
        op_q       <= div_op_t'(op);
        neg_quot_q <= (a_neg ^ b_neg) & (|divisor);
        neg_rem_q  <= a_neg;
        quot_q     <= a_abs;
        dsr_q      <= b_abs;
        rem_q      <= '0;
        cnt_q      <= CW'(XLEN);
      end else if (state_q == CALC) begin
        rem_q  <= step_rem;
        quot_q <= {quot_q[XLEN-2:0], step_q};
        cnt_q  <= cnt_q - CW'(1);
      end else if (state_q == FIX) begin
        result_q <= op_q[1] ? rem_fix : quot_fix;
        done_q   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_div_unit_seq.sv
// tb_div_unit_seq: directed vector table plus hand-written multi-cycle sequences
module tb_div_unit_seq;
  localparam int LN = 34;
`ifdef DIV_UNIT_EARLY_OUT_EN
  localparam int LS = 1;
`else
  localparam int LS = 34;
`endif
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, busy, done;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0, divisor = '0, result;
  int total = 0, bad = 0;
  div_unit_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, exp;
    int          lat;
    string       nm;
  } vec_t;
  vec_t v[16];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; dividend = a; divisor = b; start = 1'b1;
  endtask
  // counts edges from the sampling edge up to done, bounded
  task automatic wait_done(output int n, output bit busy_ok);
    n = 0; busy_ok = 1'b1;
    do begin
      @(posedge clk); #1; n++;
      start = 1'b0;
      if (!done && !busy) busy_ok = 1'b0;
    end while (!done && n < 100);
  endtask
  initial begin
    int n, k;
    bit bok;
    v[0]  = '{2'b01, 32'd100, 32'd7, 32'd14, LN, "divu_100_7"};
    v[1]  = '{2'b11, 32'd100, 32'd7, 32'd2, LN, "remu_100_7"};
    v[2]  = '{2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LN, "div_m7_2"};
    v[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LN, "rem_m7_2"};
    v[4]  = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, LN, "rem_7_m2"};
    v[5]  = '{2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, LN, "div_7_m2"};
    v[6]  = '{2'b01, 32'h12345678, 32'd0, 32'hFFFFFFFF, LS, "divu_by0"};
    v[7]  = '{2'b11, 32'h12345678, 32'd0, 32'h12345678, LS, "remu_by0"};
    v[8]  = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LS, "div_ovf"};
    v[9]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, LS, "rem_ovf"};
    v[10] = '{2'b00, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, LS, "div_m7_by0"};
    v[11] = '{2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, LS, "rem_m7_by0"};
    v[12] = '{2'b01, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, LN, "divu_big"};
    v[13] = '{2'b11, 32'hFFFFFFFF, 32'h10, 32'h0000000F, LN, "remu_big"};
    v[14] = '{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0, LN, "divu_no_ovf"};
    v[15] = '{2'b00, 32'h80000000, 32'd1, 32'h80000000, LN, "div_minneg_1"};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    rst = 1'b0;
    foreach (v[i]) begin
      @(negedge clk);
      drive(v[i].op, v[i].a, v[i].b);
      wait_done(n, bok);
      chk({v[i].nm, "_lat"}, n, v[i].lat);
      chk({v[i].nm, "_res"}, result, v[i].exp);
      chk({v[i].nm, "_busy"}, bok, 1);
      chk({v[i].nm, "_busy_done"}, busy, 0);
      @(posedge clk); #1;
      chk({v[i].nm, "_pulse"}, done, 0);
      chk({v[i].nm, "_hold"}, result, v[i].exp);
    end
    // second start while busy must be ignored
    @(negedge clk);
    drive(2'b01, 32'd100, 32'd7);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 4) drive(2'b00, 32'd1000, 32'd3);
      else start = 1'b0;
      if (n > 1 && n < 34) op = 2'b11;
    end while (!done && n < 100);
    chk("ignore_start_lat", n, LN);
    chk("ignore_start_res", result, 14);
    // reset mid-operation aborts without a done
    @(negedge clk);
    drive(2'b01, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; start = 1'b0; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_result", result, 0);
    k = 0;
    repeat (40) begin @(posedge clk); #1; if (done) k++; end
    chk("rst_mid_no_done", k, 0);
    // back-to-back: start in the done cycle is accepted
    @(negedge clk);
    drive(2'b01, 32'd100, 32'd7);
    wait_done(n, bok);
    chk("b2b_first_res", result, 14);
    drive(2'b01, 32'hFFFFFFFF, 32'd1);
    wait_done(n, bok);
    chk("b2b_second_lat", n, LN);
    chk("b2b_second_res", result, 32'hFFFFFFFF);
    chk("b2b_second_busy", bok, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_hold", result, 32'hFFFFFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
